// File: rtl/seg_pkg.sv
// Character codes, segment patterns and the code->segment decode shared by the seven-segment scan driver.
package seg_pkg;

    typedef enum logic {
        GUARD,
        DRIVE
    } scan_state_t;

    localparam logic [4:0] CH_BLANK = 5'd10;
    localparam logic [4:0] CH_A     = 5'd11;
    localparam logic [4:0] CH_B_LO  = 5'd12;
    localparam logic [4:0] CH_C     = 5'd13;
    localparam logic [4:0] CH_C_LO  = 5'd14;
    localparam logic [4:0] CH_D_LO  = 5'd15;
    localparam logic [4:0] CH_E     = 5'd16;
    localparam logic [4:0] CH_F     = 5'd17;
    localparam logic [4:0] CH_H     = 5'd18;
    localparam logic [4:0] CH_H_LO  = 5'd19;
    localparam logic [4:0] CH_L     = 5'd20;
    localparam logic [4:0] CH_L_LO  = 5'd21;
    localparam logic [4:0] CH_O     = 5'd22;
    localparam logic [4:0] CH_O_LO  = 5'd23;
    localparam logic [4:0] CH_P     = 5'd24;
    localparam logic [4:0] CH_R_LO  = 5'd25;
    localparam logic [4:0] CH_S     = 5'd26;
    localparam logic [4:0] CH_U     = 5'd27;
    localparam logic [4:0] CH_U_LO  = 5'd28;
    localparam logic [4:0] CH_DASH  = 5'd29;

    // Patterns are {g,f,e,d,c,b,a}, indexed by character code.
    localparam logic [6:0] SEG_TABLE [0:31] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h77, 7'h7C, 7'h39, 7'h58, 7'h5E,
        7'h79, 7'h71, 7'h76, 7'h74, 7'h38, 7'h30, 7'h3F, 7'h5C,
        7'h73, 7'h50, 7'h6D, 7'h3E, 7'h1C, 7'h40, 7'h00, 7'h00
    };

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg_char_rom.sv
// Combinational character ROM: 5-bit display code to 7-bit {g..a} segment pattern.
module seg_char_rom
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    assign pattern = seg_decode(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered frame and one-cycle guard.
// Optional SEG_BLINK_EN adds the blink_mask port and a frame-counted blink phase.
//
// state | meaning
// GUARD | all digits off; leaves one cycle after a tick
// DRIVE | digit[idx] lit with its decoded pattern
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [5*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              SegmentOut,
    output logic [NUM_DIGITS-1:0]   DigitEnable
);

    localparam int DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         CNT_MAX  = CW'(DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] EN_ONE   = NUM_DIGITS'(1);

    if (DIV < 3) begin : g_bad_div
        $error("seg_scan_driver: per-digit dwell DIV=%0d must be at least 3", DIV);
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("seg_scan_driver: BLINK_FRAMES must be at least 1");
    end

    scan_state_t             state, state_n;
    logic [CW-1:0]           cnt;
    logic                    tick, tick_q, wrap;
    logic [IW-1:0]           idx, idx_n;
    logic [5*NUM_DIGITS-1:0] shadow_code, frame_code;
    logic [NUM_DIGITS-1:0]   shadow_dp, frame_dp;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    lead;
    logic [4:0]              rom_code;
    logic [6:0]              pattern;
    logic                    blink_off;
    logic [7:0]              seg_lit;

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        wrap    = 1'b0;
        case (state)
            GUARD: if (tick_q) state_n = DRIVE;
            DRIVE: if (tick) begin
                state_n = GUARD;
                wrap    = (idx == IDX_MAX);
                idx_n   = wrap ? '0 : idx + 1'b1;
            end
            default: state_n = GUARD;
        endcase
    end

    // Zeros are blanked from the MSD down until the first non-zero; digit 0 always shows.
    always_comb begin
        lz_blank = '0;
        lead     = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead        = lead && (frame_code[5*i +: 5] == 5'd0);
            lz_blank[i] = lead;
        end
    end

    assign rom_code = lz_blank[idx] ? CH_BLANK : frame_code[5*idx +: 5];

    seg_char_rom u_rom (
        .code    (rom_code),
        .pattern (pattern)
    );

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_off = blink_phase && blink_mask[idx];
`else
    assign blink_off = 1'b0;
`endif

    assign seg_lit = blink_off ? 8'h00 : {frame_dp[idx], pattern};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= GUARD;
            cnt         <= '0;
            tick_q      <= 1'b0;
            idx         <= '0;
            shadow_code <= {NUM_DIGITS{CH_BLANK}};
            shadow_dp   <= '0;
            frame_code  <= {NUM_DIGITS{CH_BLANK}};
            frame_dp    <= '0;
            SegmentOut  <= SEG_IDLE;
            DigitEnable <= EN_IDLE;
        end else begin
            state  <= state_n;
            cnt    <= tick ? '0 : cnt + 1'b1;
            tick_q <= tick;
            idx    <= idx_n;
            if (load) begin
                shadow_code <= digit_data;
                shadow_dp   <= dp_in;
            end
            // A load on the wrap edge lands in the shadow and reaches the frame one frame later.
            if (wrap) begin
                frame_code <= shadow_code;
                frame_dp   <= shadow_dp;
            end
            if (state_n == DRIVE) begin
                SegmentOut  <= seg_lit ^ SEG_IDLE;
                DigitEnable <= (EN_ONE << idx) ^ EN_IDLE;
            end else begin
                SegmentOut  <= SEG_IDLE;
                DigitEnable <= EN_IDLE;
            end
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed driver for an N-digit seven-segment display with decimal points. It accepts packed 5-bit character codes (digits, letters, blank, dash), double-buffers them so a frame never tears, and scans one digit at a time with a one-cycle anti-ghosting guard. It sits between the datapath that produces display codes and the board's segment and digit-enable pins, and replaces per-digit combinational decoding.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- CLK_HZ, 50_000_000: input clock frequency.
- REFRESH_HZ, 1000: full-frame refresh rate. Per-digit dwell DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles; elaboration error if DIV < 3.
- ACTIVE_LOW, 0: 1 inverts both SegmentOut and DigitEnable (common-anode boards).
- BLINK_FRAMES, 250: frames per blink half-period (used only with SEG_BLINK_EN).

- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- digit_data  in  5*NUM_DIGITS  character codes; digit i at [5i+4:5i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- load  in  1  capture digit_data/dp_in into shadow register.
- blank_lz  in  1  leading-zero blanking enable.
- blink_mask  in  NUM_DIGITS  digits to blink (present only with SEG_BLINK_EN).
- SegmentOut  out  8  {dp,g,f,e,d,c,b,a}, registered.
- DigitEnable  out  NUM_DIGITS  one-hot digit select, registered.

## Operation
- Character codes: 0-9 digits; 10 blank; 11 A, 12 b, 13 C, 14 c, 15 d, 16 E, 17 F, 18 H, 19 h, 20 L (0111000), 21 l (0110000), 22 O, 23 o, 24 P, 25 r, 26 S, 27 U, 28 u, 29 '-' (1000000); 30-31 blank. Every code is unique; no overlaps.
- Shadow register: written on any cycle with load=1. Frame register: copied from shadow when scan index wraps NUM_DIGITS-1 -> 0; a load on that same edge reaches the frame one frame later.
- Leading-zero blanking (blank_lz=1): code-0 digits from the most significant digit downward display blank until the first non-zero code; digit 0 is always shown. DP of a blanked digit still follows dp_in. Evaluated on the frame register.
- Scan: divider counts 0..DIV-1 and wraps; tick when count = DIV-1. States: GUARD (all digits off), DRIVE (one digit on).
- Reset: divider 0, index 0, shadow and frame all code 10, dp 0, DigitEnable all off, SegmentOut all off (levels inverted if ACTIVE_LOW), state GUARD.

## Timing
- Tick at cycle T (in DRIVE): at T+1 DigitEnable off, SegmentOut off, index advances (frame latch on wrap); at T+2 DRIVE, DigitEnable one-hot[index], SegmentOut = decoded code of new digit.
- Each digit is lit DIV-1 cycles per dwell; guard is exactly 1 cycle.
- After Reset release, first tick at cycle DIV-1, digit 0 lit from cycle DIV+1 showing blank until first frame latch.
- Reset asserted mid-scan: outputs off immediately (asynchronous), no partial digit on release.

## Configuration
- SEG_BLINK_EN defined: blink_mask port exists; phase bit toggles every BLINK_FRAMES frame wraps; while phase=1, masked digits drive SegmentOut all off (including dp) but DigitEnable scans normally. Phase resets to 0.
- Undefined: no blink_mask port, no blink counter; behaviour otherwise identical.

## Structure
- Package seg_pkg: character code constants (CH_BLANK, CH_DASH, letter codes), segment pattern constants, decode function code->7-bit pattern.
- Sub-module seg_char_rom: combinational 5-bit code -> 7-bit pattern, instantiated once on the selected digit.

## Test plan
- NUM_DIGITS=4, DIV=5: after Reset, load codes {3,2,1,0} -> DigitEnable sequence 0001,0000,0010,0000,0100,... each lit 4 cycles; SegmentOut for digit 0 = 00111111.
- Load {0,0,4,0}, blank_lz=1 -> digits 3,2 off, digit 1 = 01100110, digit 0 = 00111111; blank_lz=0 -> digits 3,2 = 00111111.
- Load pulse mid-frame changing digit 0 from 5 to 6 -> remaining digits of current frame unchanged; new value visible only after wrap.
- Codes 20,25,29 with dp_in=0001 -> SegmentOut 10111000 at digit 0, 01010000, 01000000.
- ACTIVE_LOW=1 -> reset outputs all ones; lit digit enable 1110.
- SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=0010 -> digit 1 segments off in frames 2-3, on in 0-1 and 4-5; others unaffected.
